// File: rtl/wishbone_master_arbiter_if.sv
// One Wishbone link; the master modport drives the request, the slave modport answers it.
interface wishbone_master_arbiter_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        ack;
  logic        err;
  logic        irq;

  modport master (output cyc, stb, we, sel, adr, wdat, input rdat, ack, err, irq);
  modport slave  (input cyc, stb, we, sel, adr, wdat, output rdat, ack, err, irq);
endinterface

// File: rtl/wishbone_master_arbiter.sv
// Two-master round-robin Wishbone arbiter onto one interconnect master port.
// Define WB_ARB_TIMEOUT_EN to add the stalled-slave watchdog (err pulse + forced release).
//
//   state | meaning
//   IDLE  | no grant, bus outputs held at 0
//   GNT0  | master 0 owns the bus until it drops cyc
//   GNT1  | master 1 owns the bus until it drops cyc
module wishbone_master_arbiter #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  wishbone_master_arbiter_if.slave    m0,
  wishbone_master_arbiter_if.slave    m1,
  wishbone_master_arbiter_if.master   s
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state_q;
  state_t state_d;
  logic   last_gnt;
  logic   abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_d == GNT0 && state_q != GNT0)
        last_gnt <= 1'b0;
      else if (state_d == GNT1 && state_q != GNT1)
        last_gnt <= 1'b1;
    end
  end

  // Release hands straight over to a waiting master, so there is no idle bubble.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (m0.cyc && m1.cyc)
          state_d = last_gnt ? GNT0 : GNT1;
        else if (m0.cyc)
          state_d = GNT0;
        else if (m1.cyc)
          state_d = GNT1;
      end
      GNT0: if (!m0.cyc || abort) state_d = m1.cyc ? GNT1 : IDLE;
      GNT1: if (!m1.cyc || abort) state_d = m0.cyc ? GNT0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s.cyc   = 1'b0;
    s.stb   = 1'b0;
    s.we    = 1'b0;
    s.sel   = 4'h0;
    s.adr   = 32'h0;
    s.wdat  = 32'h0;
    m0.ack  = 1'b0;
    m0.rdat = 32'h0;
    m0.err  = 1'b0;
    m1.ack  = 1'b0;
    m1.rdat = 32'h0;
    m1.err  = 1'b0;
    case (state_q)
      GNT0: begin
        s.cyc   = m0.cyc & ~abort;
        s.stb   = m0.stb & ~abort;
        s.we    = m0.we;
        s.sel   = m0.sel;
        s.adr   = m0.adr;
        s.wdat  = m0.wdat;
        m0.ack  = s.ack & m0.stb & ~abort;
        m0.rdat = s.rdat;
        m0.err  = abort;
      end
      GNT1: begin
        s.cyc   = m1.cyc & ~abort;
        s.stb   = m1.stb & ~abort;
        s.we    = m1.we;
        s.sel   = m1.sel;
        s.adr   = m1.adr;
        s.wdat  = m1.wdat;
        m1.ack  = s.ack & m1.stb & ~abort;
        m1.rdat = s.rdat;
        m1.err  = abort;
      end
      default: ;
    endcase
  end

  assign m0.irq = s.irq;
  assign m1.irq = s.irq;

`ifdef WB_ARB_TIMEOUT_EN
  logic [CNT_WIDTH-1:0] wd_cnt;
  logic                 stalled;

  assign stalled = (state_q != IDLE) && s.stb && !s.ack;

  // abort is registered, so the err pulse lands the cycle after the last stalled count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
      abort  <= 1'b0;
    end else begin
      abort <= stalled && (state_d == state_q) &&
               (wd_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
      if (abort || !stalled || state_d != state_q)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign abort = 1'b0;
`endif

endmodule

// File: tb/tb_wishbone_master_arbiter.sv
// Randomized two-master bench with a transaction-level grant model and per-master scoreboards.
module tb_wishbone_master_arbiter;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wishbone_master_arbiter_if m0_bus ();
  wishbone_master_arbiter_if m1_bus ();
  wishbone_master_arbiter_if s_bus ();

  wishbone_master_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .m0(m0_bus), .m1(m1_bus), .s(s_bus)
  );

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdat;
  } tx_t;

  logic        cyc_d [2];
  logic        stb_d [2];
  logic        we_d  [2];
  logic [3:0]  sel_d [2];
  logic [31:0] adr_d [2];
  logic [31:0] wdat_d[2];
  logic        s_ack, s_irq;
  logic [31:0] s_rdat;
  bit          hang, model_on;
  int          n_tests = 0, n_fail = 0;
  tx_t         q0[$], q1[$];

  logic        ack_o [2];
  logic        err_o [2];
  logic        irq_o [2];
  logic [31:0] rdat_o[2];

  assign m0_bus.cyc = cyc_d[0];  assign m1_bus.cyc = cyc_d[1];
  assign m0_bus.stb = stb_d[0];  assign m1_bus.stb = stb_d[1];
  assign m0_bus.we  = we_d[0];   assign m1_bus.we  = we_d[1];
  assign m0_bus.sel = sel_d[0];  assign m1_bus.sel = sel_d[1];
  assign m0_bus.adr = adr_d[0];  assign m1_bus.adr = adr_d[1];
  assign m0_bus.wdat = wdat_d[0]; assign m1_bus.wdat = wdat_d[1];
  assign s_bus.ack  = s_ack;
  assign s_bus.rdat = s_rdat;
  assign s_bus.irq  = s_irq;
  assign s_bus.err  = 1'b0;
  assign ack_o[0] = m0_bus.ack;   assign ack_o[1] = m1_bus.ack;
  assign err_o[0] = m0_bus.err;   assign err_o[1] = m1_bus.err;
  assign irq_o[0] = m0_bus.irq;   assign irq_o[1] = m1_bus.irq;
  assign rdat_o[0] = m0_bus.rdat; assign rdat_o[1] = m1_bus.rdat;

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: owner of the bus (-1 none) and the last master granted, from the round-robin rules.
  int own, last;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      own  = -1;
      last = 1;
    end else begin
      int nxt;
      nxt = own;
      if (own < 0) begin
        if (cyc_d[0] && cyc_d[1]) nxt = 1 - last;
        else if (cyc_d[0])        nxt = 0;
        else if (cyc_d[1])        nxt = 1;
      end else if (!cyc_d[own]) begin
        nxt = cyc_d[1 - own] ? 1 - own : -1;
      end
      if (nxt >= 0 && nxt != own) last = nxt;
      own = nxt;
    end
  end

  // Slave: random 0..2 wait states, occasional stray ack while stb is low, random irq.
  initial begin
    int wait_n;
    wait_n = 0;
    forever begin
      @(posedge clk);
      #2;
      s_irq = 1'($urandom_range(0, 1));
      if (!hang && s_bus.cyc && s_bus.stb) begin
        if (wait_n == 0) begin
          s_ack  = 1'b1;
          s_rdat = slave_data(s_bus.adr);
          wait_n = $urandom_range(0, 2);
        end else begin
          s_ack  = 1'b0;
          s_rdat = $urandom;
          wait_n--;
        end
      end else if (!hang && s_bus.cyc) begin
        s_ack = ($urandom_range(0, 3) == 0);
      end else begin
        s_ack = 1'b0;
      end
    end
  end

  // Cycle monitor against the reference owner.
  always @(negedge clk) begin
    if (model_on && !rst) begin
      logic [70:0] exp_s;
      exp_s = '0;
      if (own >= 0)
        exp_s = {cyc_d[own], stb_d[own], we_d[own], sel_d[own], adr_d[own], wdat_d[own]};
      check("s_bus_route", {s_bus.cyc, s_bus.stb, s_bus.we, s_bus.sel, s_bus.adr, s_bus.wdat}, exp_s);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("m%0d_ack", i), ack_o[i], (own == i) && s_ack && stb_d[i]);
        check($sformatf("m%0d_rdat", i), rdat_o[i], (own == i) ? s_rdat : 32'h0);
        check($sformatf("m%0d_err", i), err_o[i], 1'b0);
      end
      check("irq_fanout", {irq_o[0], irq_o[1]}, {s_irq, s_irq});
    end
  end

  // Scoreboard: each ack retires the oldest issued transfer of that master.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (ack_o[i]) begin
          if ((i == 0 ? q0.size() : q1.size()) == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL m%0d_unexpected_ack: got ack with no transfer outstanding, required none", i);
          end else begin
            tx_t e;
            if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
            check($sformatf("m%0d_sb_rdat", i), rdat_o[i], slave_data(e.adr));
            check($sformatf("m%0d_sb_req", i), {s_bus.we, s_bus.sel, s_bus.adr, s_bus.wdat},
                  {e.we, e.sel, e.adr, e.wdat});
          end
        end
      end
    end
  end

  task automatic run_master(input int id, input int ntx);
    for (int t = 0; t < ntx; t++) begin
      int nb;
      nb = $urandom_range(1, 3);
      @(posedge clk); #1;
      cyc_d[id] = 1'b1;
      for (int b = 0; b < nb; b++) begin
        tx_t e;
        int  waited;
        e.we   = 1'($urandom_range(0, 1));
        e.sel  = 4'($urandom);
        e.adr  = {id[0], 29'($urandom), 2'b00};
        e.wdat = $urandom;
        we_d[id] = e.we; sel_d[id] = e.sel; adr_d[id] = e.adr; wdat_d[id] = e.wdat;
        stb_d[id] = 1'b1;
        if (id == 0) q0.push_back(e); else q1.push_back(e);
        waited = 0;
        do begin
          @(negedge clk);
          waited++;
        end while (!ack_o[id] && waited < 300);
        if (!ack_o[id]) begin
          n_tests++;
          n_fail++;
          $display("FAIL m%0d_ack_timeout: got no ack in %0d cycles, required an ack", id, waited);
        end
        @(posedge clk); #1;
        if (b < nb - 1 && $urandom_range(0, 1) == 1) begin
          stb_d[id] = 1'b0;
          @(posedge clk); #1;
        end
      end
      stb_d[id] = 1'b0;
      cyc_d[id] = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int first, errk, nerr, w;
    logic stb_at_err, m1_next;
    for (int i = 0; i < 2; i++) begin
      cyc_d[i] = 0; stb_d[i] = 0; we_d[i] = 0; sel_d[i] = 0; adr_d[i] = 0; wdat_d[i] = 0;
    end
    s_ack = 0; s_rdat = 0; s_irq = 0; hang = 0; model_on = 0;

    repeat (2) @(negedge clk);
    check("rst_s_bus", {s_bus.cyc, s_bus.stb, s_bus.we, s_bus.sel, s_bus.adr, s_bus.wdat}, 71'h0);
    check("rst_m_out", {ack_o[0], err_o[0], rdat_o[0], ack_o[1], err_o[1], rdat_o[1]}, 68'h0);
    check("rst_irq", {irq_o[0], irq_o[1]}, {s_irq, s_irq});
    @(posedge clk); #1;
    rst = 1'b0;
    model_on = 1;

    fork
      run_master(0, 40);
      run_master(1, 40);
    join
    repeat (3) @(posedge clk);
    check("sb_drained", q0.size() + q1.size(), 0);

    // Hung slave: m0 alone, m1 joins while m0 is stalled.
    @(posedge clk); #1;
    model_on = 0;
    hang = 1;
    cyc_d[0] = 1; stb_d[0] = 1; we_d[0] = 1; sel_d[0] = 4'hf;
    adr_d[0] = 32'h0000_0010; wdat_d[0] = 32'hDEAD_BEEF;
    first = -1; errk = -1; nerr = 0; stb_at_err = 1'b1; m1_next = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (first < 0 && s_bus.stb) first = k;
      if (errk >= 0 && k == errk + 1) m1_next = s_bus.cyc && (s_bus.adr == adr_d[1]);
      if (err_o[0]) begin
        nerr++;
        if (errk < 0) begin errk = k; stb_at_err = s_bus.stb; end
        cyc_d[0] = 0; stb_d[0] = 0;
      end
      if (k == 1) begin
        cyc_d[1] = 1; stb_d[1] = 1; we_d[1] = 0; sel_d[1] = 4'hf;
        adr_d[1] = 32'h8100_0004; wdat_d[1] = 32'h0;
      end
    end
`ifdef WB_ARB_TIMEOUT_EN
    check("wd_err_delay", errk - first, TO);
    check("wd_err_width", nerr, 1);
    check("wd_stb_at_err", stb_at_err, 1'b0);
    check("wd_m1_granted_next", m1_next, 1'b1);
`else
    check("no_wd_err", nerr, 0);
    check("no_wd_grant_held", {s_bus.cyc, s_bus.stb, s_bus.adr}, {1'b1, 1'b1, 32'h0000_0010});
`endif

    // Reset mid-transfer while m1 owns the bus.
    @(posedge clk); #1;
    cyc_d[0] = 0; stb_d[0] = 0;
    cyc_d[1] = 1; stb_d[1] = 1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(s_bus.stb && s_bus.adr == adr_d[1]) && w < 30);
    check("gnt1_before_rst", {s_bus.stb, s_bus.adr}, {1'b1, adr_d[1]});
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_rst_clears", {s_bus.cyc, s_bus.stb, ack_o[1], rdat_o[1]}, 35'h0);
    cyc_d[0] = 1; stb_d[0] = 1; adr_d[0] = 32'h0000_0020;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    model_on = 1;
    @(negedge clk);
    check("post_rst_idle", s_bus.cyc, 1'b0);
    @(negedge clk);
    check("post_rst_tie_m0", {s_bus.cyc, s_bus.adr}, {1'b1, 32'h0000_0020});
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
